// File: rtl/chrono_ctrl_if.sv
// rtl/chrono_ctrl_if.sv - button/tick inputs and display-side outputs of chrono_ctrl
interface chrono_ctrl_if #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 4
);
    localparam int LC_W = $clog2(LAP_DEPTH + 1);
    localparam int LI_W = $clog2(LAP_DEPTH);

    logic             tick;
    logic             pb_mode;
    logic             pb_act;
    logic [CNT_W-1:0] disp_val;
    logic [1:0]       disp_sel;
    logic             alarm;
    logic             running;
    logic [LC_W-1:0]  lap_cnt;
    logic [LI_W-1:0]  lap_idx;

    modport master (
        output tick, pb_mode, pb_act,
        input  disp_val, disp_sel, alarm, running, lap_cnt, lap_idx
    );

    modport slave (
        input  tick, pb_mode, pb_act,
        output disp_val, disp_sel, alarm, running, lap_cnt, lap_idx
    );
endinterface

// File: rtl/chrono_ctrl.sv
// rtl/chrono_ctrl.sv - stopwatch/countdown controller with circular lap memory
module chrono_ctrl #(
    parameter int CNT_W     = 16,
    parameter int LAP_DEPTH = 4
) (
    input  logic          clk,
    input  logic          nrst,
    chrono_ctrl_if.slave  bus
);
    localparam int LC_W = $clog2(LAP_DEPTH + 1);
    localparam int LI_W = $clog2(LAP_DEPTH);
    localparam logic [LC_W-1:0] LAP_FULL = LC_W'(LAP_DEPTH);

    typedef enum logic [2:0] {
        IDLE, SW_RUN, SW_STOP, REVIEW, SET, COUNTDOWN, EXPIRED
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n, preset, preset_n;
    logic [LI_W-1:0]  wr_ptr, wr_ptr_n, old_ptr, old_ptr_n, lap_idx, lap_idx_n;
    logic [LC_W-1:0]  lap_cnt, lap_cnt_n;
    logic             mode_q, act_q, lap_we;
    logic [CNT_W-1:0] lap_mem [LAP_DEPTH];

    // Mode wins a simultaneous press; the action press is simply lost.
    wire mode_p = bus.pb_mode & ~mode_q;
    wire act_p  = bus.pb_act & ~act_q & ~mode_p;
    wire [CNT_W-1:0] count_sat = (&count) ? count : count + 1'b1;
    wire [LI_W-1:0]  newest    = wr_ptr - 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            count   <= '0;
            preset  <= '0;
            wr_ptr  <= '0;
            old_ptr <= '0;
            lap_cnt <= '0;
            lap_idx <= '0;
            mode_q  <= 1'b1;
            act_q   <= 1'b1;
        end else begin
            state   <= state_n;
            count   <= count_n;
            preset  <= preset_n;
            wr_ptr  <= wr_ptr_n;
            old_ptr <= old_ptr_n;
            lap_cnt <= lap_cnt_n;
            lap_idx <= lap_idx_n;
            mode_q  <= bus.pb_mode;
            act_q   <= bus.pb_act;
        end
    end

    always_ff @(posedge clk) begin
        if (lap_we) lap_mem[wr_ptr] <= count;
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        preset_n  = preset;
        wr_ptr_n  = wr_ptr;
        old_ptr_n = old_ptr;
        lap_cnt_n = lap_cnt;
        lap_idx_n = lap_idx;
        lap_we    = 1'b0;
        case (state)
            IDLE: begin
                count_n = '0;
                if (mode_p)     state_n = SW_RUN;
                else if (act_p) state_n = SET;
            end
            SW_RUN: begin
                if (bus.tick) count_n = count_sat;
                if (mode_p) begin
                    state_n = SW_STOP;
                end else if (act_p) begin
                    lap_we   = 1'b1;
                    wr_ptr_n = wr_ptr + 1'b1;
                    // Full memory: the write lands on the oldest slot, so oldest moves on.
                    if (lap_cnt == LAP_FULL) old_ptr_n = old_ptr + 1'b1;
                    else                     lap_cnt_n = lap_cnt + 1'b1;
                end
            end
            SW_STOP: begin
                if (mode_p) begin
                    state_n   = REVIEW;
                    lap_idx_n = (lap_cnt == '0) ? '0 : old_ptr;
                end else if (act_p) begin
                    state_n = SW_RUN;
                end
            end
            REVIEW: begin
                if (mode_p) begin
                    state_n   = IDLE;
                    count_n   = '0;
                    lap_cnt_n = '0;
                    wr_ptr_n  = '0;
                    old_ptr_n = '0;
                    lap_idx_n = '0;
                end else if (act_p && lap_cnt != '0) begin
                    lap_idx_n = (lap_idx == newest) ? old_ptr : lap_idx + 1'b1;
                end
            end
            SET: begin
                if (mode_p) begin
                    if (preset != '0) begin
                        state_n = COUNTDOWN;
                        count_n = preset;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (act_p) begin
                    preset_n = preset + 1'b1;
                end
            end
            COUNTDOWN: begin
                if (mode_p) begin
                    state_n = IDLE;
                    count_n = '0;
                end else if (bus.tick) begin
                    if (count <= CNT_W'(1)) begin
                        state_n = EXPIRED;
                        count_n = '0;
                    end else begin
                        count_n = count - 1'b1;
                    end
                end
            end
            EXPIRED: begin
                if (mode_p || act_p) begin
                    state_n = IDLE;
                    count_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.disp_val = '0;
        bus.disp_sel = 2'b00;
        case (state)
            SW_RUN, SW_STOP: begin
                bus.disp_val = count;
                bus.disp_sel = 2'b01;
            end
            REVIEW: begin
                bus.disp_val = (lap_cnt == '0) ? '0 : lap_mem[lap_idx];
                bus.disp_sel = 2'b10;
            end
            SET: begin
                bus.disp_val = preset;
                bus.disp_sel = 2'b11;
            end
            COUNTDOWN, EXPIRED: begin
                bus.disp_val = count;
                bus.disp_sel = 2'b11;
            end
            default: begin
                bus.disp_val = '0;
                bus.disp_sel = 2'b00;
            end
        endcase
    end

    assign bus.alarm   = (state == EXPIRED);
    assign bus.running = (state == SW_RUN) || (state == COUNTDOWN);
    assign bus.lap_cnt = lap_cnt;
    assign bus.lap_idx = lap_idx;
endmodule

// File: tb/tb_chrono_ctrl.sv
// tb/tb_chrono_ctrl.sv - directed scoreboard bench for chrono_ctrl
module tb_chrono_ctrl;
    localparam int CNT_W     = 8;
    localparam int LAP_DEPTH = 4;

    localparam int F_VAL = 0, F_SEL = 1, F_ALM = 2, F_RUN = 3, F_LCNT = 4, F_LIDX = 5;

    typedef struct {
        string tag;
        int    fld;
        int    val;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    chrono_ctrl_if #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) bus ();

    chrono_ctrl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int observe(input int fld);
        case (fld)
            F_VAL:   return int'(bus.disp_val);
            F_SEL:   return int'(bus.disp_sel);
            F_ALM:   return int'(bus.alarm);
            F_RUN:   return int'(bus.running);
            F_LCNT:  return int'(bus.lap_cnt);
            default: return int'(bus.lap_idx);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int fld, input int val);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        int   obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.fld);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        bus.pb_mode = 1'b1;
        cycle();
        bus.pb_mode = 1'b0;
        cycle();
    endtask

    task automatic press_act();
        bus.pb_act = 1'b1;
        cycle();
        bus.pb_act = 1'b0;
        cycle();
    endtask

    task automatic ticks(input int n);
        bus.tick = 1'b1;
        cycle(n);
        bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.pb_mode = 1'b1;
        bus.pb_act  = 1'b0;

        // Reset with mode held: no press may fire after release.
        cycle(2);
        expect_val("rst_val", F_VAL, 0);
        expect_val("rst_sel", F_SEL, 0);
        expect_val("rst_alarm", F_ALM, 0);
        expect_val("rst_run", F_RUN, 0);
        expect_val("rst_lcnt", F_LCNT, 0);
        expect_val("rst_lidx", F_LIDX, 0);
        check();
        nrst = 1'b1;
        cycle(3);
        expect_val("held_sel", F_SEL, 0);
        expect_val("held_run", F_RUN, 0);
        check();
        bus.pb_mode = 1'b0;
        cycle();

        // Basic run, one lap, stop and review.
        press_mode();
        expect_val("run_sel", F_SEL, 1);
        expect_val("run_run", F_RUN, 1);
        check();
        ticks(5);
        press_act();
        ticks(3);
        press_mode();
        expect_val("stop_val", F_VAL, 8);
        expect_val("stop_lcnt", F_LCNT, 1);
        expect_val("stop_run", F_RUN, 0);
        check();
        press_mode();
        expect_val("rev1_val", F_VAL, 5);
        expect_val("rev1_sel", F_SEL, 2);
        expect_val("rev1_idx", F_LIDX, 0);
        check();
        press_mode();
        expect_val("idle_sel", F_SEL, 0);
        expect_val("idle_lcnt", F_LCNT, 0);
        check();

        // Six laps into four slots, tick coinciding with stop.
        press_mode();
        for (int i = 1; i <= 6; i++) begin
            ticks(1);
            press_act();
        end
        expect_val("laps_lcnt", F_LCNT, 4);
        check();
        bus.tick    = 1'b1;
        bus.pb_mode = 1'b1;
        cycle();
        bus.tick    = 1'b0;
        bus.pb_mode = 1'b0;
        cycle();
        expect_val("tick_stop_val", F_VAL, 7);
        expect_val("tick_stop_sel", F_SEL, 1);
        check();
        press_mode();
        expect_val("wrap_val0", F_VAL, 3);
        expect_val("wrap_idx0", F_LIDX, 2);
        check();
        press_act();
        expect_val("wrap_val1", F_VAL, 4);
        expect_val("wrap_idx1", F_LIDX, 3);
        check();
        press_act();
        expect_val("wrap_val2", F_VAL, 5);
        expect_val("wrap_idx2", F_LIDX, 0);
        check();
        press_act();
        expect_val("wrap_val3", F_VAL, 6);
        check();
        press_act();
        expect_val("wrap_val4", F_VAL, 3);
        expect_val("wrap_idx4", F_LIDX, 2);
        check();
        press_mode();

        // Saturation, then review with no laps.
        press_mode();
        ticks(300);
        expect_val("sat_val", F_VAL, 255);
        check();
        ticks(5);
        expect_val("sat_hold", F_VAL, 255);
        check();
        press_mode();
        press_mode();
        expect_val("empty_val", F_VAL, 0);
        expect_val("empty_idx", F_LIDX, 0);
        check();
        press_act();
        expect_val("empty_act_idx", F_LIDX, 0);
        expect_val("empty_act_sel", F_SEL, 2);
        check();
        press_mode();

        // Countdown from 3 to expiry.
        press_act();
        repeat (3) press_act();
        expect_val("set_val", F_VAL, 3);
        expect_val("set_sel", F_SEL, 3);
        check();
        press_mode();
        expect_val("cd_val", F_VAL, 3);
        expect_val("cd_run", F_RUN, 1);
        check();
        ticks(2);
        expect_val("cd_val1", F_VAL, 1);
        expect_val("cd_alarm0", F_ALM, 0);
        check();
        ticks(1);
        expect_val("exp_alarm", F_ALM, 1);
        expect_val("exp_val", F_VAL, 0);
        expect_val("exp_run", F_RUN, 0);
        check();
        press_act();
        expect_val("exp_clr_alarm", F_ALM, 0);
        expect_val("exp_clr_sel", F_SEL, 0);
        check();

        // Preset wraps to zero; mode from SET with zero preset returns to IDLE.
        press_act();
        repeat (253) press_act();
        expect_val("preset_wrap", F_VAL, 0);
        check();
        press_mode();
        expect_val("zero_preset_sel", F_SEL, 0);
        expect_val("zero_preset_run", F_RUN, 0);
        check();

        // Abort wins over the final tick.
        press_act();
        press_act();
        press_mode();
        expect_val("cd1_val", F_VAL, 1);
        check();
        bus.tick    = 1'b1;
        bus.pb_mode = 1'b1;
        cycle();
        expect_val("abort_alarm", F_ALM, 0);
        expect_val("abort_sel", F_SEL, 0);
        check();
        bus.tick    = 1'b0;
        bus.pb_mode = 1'b0;
        cycle();
        expect_val("abort_alarm2", F_ALM, 0);
        check();

        // Asynchronous reset mid-run clears everything, including preset.
        press_mode();
        ticks(4);
        #2 nrst = 1'b0;
        #1;
        expect_val("arst_sel", F_SEL, 0);
        expect_val("arst_val", F_VAL, 0);
        expect_val("arst_run", F_RUN, 0);
        check();
        cycle();
        nrst = 1'b1;
        cycle();
        press_act();
        expect_val("arst_preset", F_VAL, 0);
        expect_val("arst_set_sel", F_SEL, 3);
        check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
